// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its neighbours.
package instr_fetch_pkg;

   localparam int         INSTR_W  = 32;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decode handshake.
interface instr_fetch_if #(
   parameter int ADDR_W = 32
);
   import instr_fetch_pkg::*;

   logic               imem_req_o;
   logic [ADDR_W-1:0]  imem_addr_o;
   logic [INSTR_W-1:0] imem_rdata_i;
   logic               instr_valid_o;
   logic               instr_ready_i;
   logic [INSTR_W-1:0] instr_o;
   logic [6:0]         opcode_o;
   logic [ADDR_W-1:0]  pc_o;

   modport master (
      output imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o,
      input  imem_rdata_i, instr_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o,
      output imem_rdata_i, instr_ready_i
   );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO of {pc, instr} entries between the memory return path and decode.
// Flush empties it in one cycle and takes precedence over push and pop.
module instr_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   i_push,
   input  logic [W-1:0]           i_data,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output logic [W-1:0]           o_data,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int             PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_full;
   logic             w_push_en;
   logic             w_pop_en;

   assign w_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign w_push_en = i_push && !w_full && !i_flush;
   assign w_pop_en  = i_pop && !o_empty && !i_flush;
   assign o_data    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   // Pointer/count update; pointers wrap on their own since DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (!rst_i || i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= w_push_en ? r_wr_ptr + 1'b1 : r_wr_ptr;
         r_rd_ptr <= w_pop_en  ? r_rd_ptr + 1'b1 : r_rd_ptr;
         case ({w_push_en, w_pop_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push_en) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, IDLE/RUN/DONE control and credit-limited issue into a small
// instruction buffer that feeds decode over valid/ready.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] END_PC   = 32'h0000_0400
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              busy_o,
   instr_fetch_if.master     bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int ENT_W = ADDR_W + INSTR_W;

   fetch_state_e       r_state;
   fetch_state_e       w_state_nxt;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  w_pc_nxt;
   logic [ADDR_W-1:0]  r_inflight_pc;
   logic               r_inflight;
   logic [ADDR_W-1:0]  w_target;
   logic               w_redirect;
   logic               w_credit_ok;
   logic               w_issue;
   logic               w_push;
   logic               w_pop;
   logic               w_empty;
   logic [CNT_W-1:0]   w_count;
   logic [ENT_W-1:0]   w_head;
   logic [ADDR_W-1:0]  w_head_pc;
   logic [INSTR_W-1:0] w_head_instr;
   logic [INSTR_W-1:0] w_instr;

   assign w_target    = redirect_pc_i & ~ADDR_W'(3);
   assign w_redirect  = redirect_i && (r_state != ST_IDLE);
   assign w_credit_ok = ({1'b0, w_count} + (CNT_W+1)'(r_inflight)) < (CNT_W+1)'(DEPTH);
   assign w_issue     = (r_state == ST_RUN) && w_credit_ok && (r_pc != END_PC) && !redirect_i;
   // A word returning in a redirect cycle belongs to the abandoned path.
   assign w_push      = r_inflight && !w_redirect;
   assign w_pop       = !w_empty && bus.instr_ready_i;

   instr_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_push  (w_push),
      .i_data  ({r_inflight_pc, bus.imem_rdata_i}),
      .i_pop   (w_pop),
      .i_flush (w_redirect),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_head_pc    = w_head[ENT_W-1:INSTR_W];
   assign w_head_instr = w_head[INSTR_W-1:0];

   // Next state and next PC; a redirect outranks a sequential issue.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      case (r_state)
         ST_IDLE: begin
            if (start_i) w_state_nxt = ST_RUN;
            else         w_state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            if (!w_redirect && !w_issue && (r_pc == END_PC)) w_state_nxt = ST_DONE;
            else                                              w_state_nxt = ST_RUN;
         end
         ST_DONE: begin
            if (w_redirect && (w_target < END_PC)) w_state_nxt = ST_RUN;
            else                                   w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_redirect)   w_pc_nxt = w_target;
      else if (w_issue) w_pc_nxt = r_pc + ADDR_W'(4);
      else              w_pc_nxt = r_pc;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state       <= ST_IDLE;
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= RESET_PC;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_inflight    <= w_issue;
         r_inflight_pc <= w_issue ? r_pc : r_inflight_pc;
      end
   end

   assign w_instr           = w_empty ? '0 : w_head_instr;
   assign bus.imem_req_o    = w_issue;
   assign bus.imem_addr_o   = r_pc;
   assign bus.instr_valid_o = !w_empty;
   assign bus.instr_o       = w_instr;
   assign bus.opcode_o      = w_instr[6:0];
   assign bus.pc_o          = w_empty ? RESET_PC : w_head_pc;
   assign busy_o            = (r_state == ST_RUN) || !w_empty || r_inflight;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, checked by a
// program-order scoreboard fed from start/redirect events.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   localparam int          ADDR_W   = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] END_PC   = 32'h0000_0200;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        busy_o;

   int n_tests = 0;
   int n_fail  = 0;
   int n_pops  = 0;

   instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

   instr_fetch #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC),
      .END_PC   (END_PC)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .busy_o        (busy_o),
      .bus           (bus)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0020: return 32'h0050_0093;
         32'h0000_0024: return 32'h0020_81B3;
         default:       return {a[15:0] ^ 16'hC35A, a[15:0] + 16'h1357};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected program-order stream of fetched PCs.
   logic [31:0] exp_q[$];
   bit          mdl_active;
   logic [31:0] e_pc;

   task automatic push_stream(input logic [31:0] t);
      for (int unsigned a = t; a < END_PC; a += 4) exp_q.push_back(a);
   endtask

   // Instruction memory: one-cycle read latency.
   logic        mem_req_q;
   logic [31:0] mem_addr_q;
   initial begin
      mem_req_q  = 1'b0;
      mem_addr_q = 32'h0;
      forever begin
         @(negedge clk_i);
         mem_req_q  = bus.imem_req_o;
         mem_addr_q = bus.imem_addr_o;
      end
   end
   initial begin
      bus.imem_rdata_i = 32'h0;
      forever begin
         @(posedge clk_i);
         #1;
         bus.imem_rdata_i = mem_req_q ? mem_word(mem_addr_q) : 32'hDEAD_BEEF;
      end
   end

   // Monitor: compare each accepted instruction, then apply this cycle's events to the model.
   initial begin
      mdl_active = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            exp_q.delete();
            mdl_active = 1'b0;
         end else begin
            if (bus.instr_valid_o && bus.instr_ready_i) begin
               n_pops++;
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_instr: got pc %h, expected no instruction", bus.pc_o);
               end else begin
                  e_pc = exp_q.pop_front();
                  check("head_pc", bus.pc_o, e_pc);
                  check("head_instr", bus.instr_o, mem_word(e_pc));
                  check("head_opcode", {25'd0, bus.opcode_o}, {25'd0, mem_word(e_pc) & 32'h7F});
                  if (e_pc == 32'h20) check("opcode_addi", {25'd0, bus.opcode_o}, {25'd0, OP_IMM});
                  if (e_pc == 32'h24) check("opcode_add", {25'd0, bus.opcode_o}, {25'd0, OP_RTYPE});
               end
            end
            if (dut.u_fifo.i_push) begin
               n_tests++;
               if (dut.u_fifo.w_full && !dut.u_fifo.i_flush) begin
                  n_fail++;
                  $display("FAIL fifo_overflow: got push into full buffer, expected none");
               end
            end
            if (mdl_active && redirect_i) begin
               exp_q.delete();
               if ((redirect_pc_i & ~32'h3) < END_PC) push_stream(redirect_pc_i & ~32'h3);
            end else if (!mdl_active && start_i) begin
               mdl_active = 1'b1;
               push_stream(RESET_PC);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      bus.instr_ready_i = 1'b1;
      while ((exp_q.size() != 0 || busy_o) && n < 600) begin
         tick(1);
         n++;
      end
      check({name, "_left"}, exp_q.size(), 32'd0);
      check({name, "_busy"}, {31'd0, busy_o}, 32'd0);
      check({name, "_valid"}, {31'd0, bus.instr_valid_o}, 32'd0);
      check({name, "_req"}, {31'd0, bus.imem_req_o}, 32'd0);
   endtask

   task automatic wait_valid(input string name, input int max);
      int n;
      n = 0;
      while (!bus.instr_valid_o && n < max) begin
         tick(1);
         n++;
      end
      check(name, {31'd0, bus.instr_valid_o}, 32'd1);
   endtask

   int snap;

   initial begin
      rst_i = 1'b0; start_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
      bus.instr_ready_i = 1'b1;
      tick(3);
      check("rst_req", {31'd0, bus.imem_req_o}, 32'd0);
      check("rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_instr", bus.instr_o, 32'd0);
      check("rst_opcode", {25'd0, bus.opcode_o}, 32'd0);
      check("rst_pc", bus.pc_o, RESET_PC);
      rst_i = 1'b1;
      tick(2);

      // Start latency, then backpressure from the first valid cycle.
      start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
      check("c1_req", {31'd0, bus.imem_req_o}, 32'd1);
      check("c1_addr", bus.imem_addr_o, 32'h0);
      check("c1_valid", {31'd0, bus.instr_valid_o}, 32'd0);
      tick(1);
      check("c2_req", {31'd0, bus.imem_req_o}, 32'd1);
      check("c2_addr", bus.imem_addr_o, 32'h4);
      check("c2_valid", {31'd0, bus.instr_valid_o}, 32'd0);
      tick(1);
      check("c3_addr", bus.imem_addr_o, 32'h8);
      check("c3_valid", {31'd0, bus.instr_valid_o}, 32'd1);
      check("c3_pc", bus.pc_o, 32'h0);
      bus.instr_ready_i = 1'b0;
      tick(5);
      check("bp_req", {31'd0, bus.imem_req_o}, 32'd0);
      check("bp_valid", {31'd0, bus.instr_valid_o}, 32'd1);
      check("bp_head", bus.pc_o, 32'h0);
      for (int i = 0; i < 20; i++) begin
         bus.instr_ready_i = ($urandom_range(0, 3) != 0);
         tick(1);
      end

      // Reset while running with a full buffer.
      bus.instr_ready_i = 1'b0;
      tick(6);
      rst_i = 1'b0;
      tick(1);
      check("mrst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
      check("mrst_req", {31'd0, bus.imem_req_o}, 32'd0);
      check("mrst_pc", bus.pc_o, RESET_PC);
      rst_i = 1'b1;
      bus.instr_ready_i = 1'b1;
      tick(3);
      check("idle_req", {31'd0, bus.imem_req_o}, 32'd0);
      check("idle_valid", {31'd0, bus.instr_valid_o}, 32'd0);

      // Redirect with two buffered words and one read in flight.
      start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
      tick(2);
      bus.instr_ready_i = 1'b0;
      tick(1);
      redirect_i = 1'b1;
      redirect_pc_i = 32'h103;
      tick(1);
      redirect_i = 1'b0;
      bus.instr_ready_i = 1'b1;
      wait_valid("redir_valid", 10);
      check("redir_pc", bus.pc_o, 32'h100);

      // Run to the end address, then resume from DONE.
      bus.instr_ready_i = 1'b0;
      redirect_i = 1'b1;
      redirect_pc_i = 32'h1F0;
      snap = n_pops;
      tick(1);
      redirect_i = 1'b0;
      drain("end");
      check("end_count", n_pops - snap, 32'd4);
      tick(5);
      check("done_valid", {31'd0, bus.instr_valid_o}, 32'd0);
      check("done_busy", {31'd0, busy_o}, 32'd0);
      redirect_i = 1'b1;
      redirect_pc_i = 32'h8 + 32'h1F0;
      snap = n_pops;
      tick(1);
      redirect_i = 1'b0;
      drain("resume");
      check("resume_count", n_pops - snap, 32'd2);

      // Unaligned redirect onto the addi/add pair.
      redirect_i = 1'b1;
      redirect_pc_i = 32'h22;
      tick(1);
      redirect_i = 1'b0;
      for (int i = 0; i < 15; i++) begin
         bus.instr_ready_i = ($urandom_range(0, 2) != 0);
         tick(1);
      end

      for (int i = 0; i < 400; i++) begin
         bus.instr_ready_i = ($urandom_range(0, 3) != 0);
         redirect_i        = ($urandom_range(0, 29) == 0);
         redirect_pc_i     = $urandom_range(0, END_PC - 1);
         start_i           = ($urandom_range(0, 19) == 0);
         rst_i             = ($urandom_range(0, 149) != 0);
         tick(1);
      end
      start_i = 1'b0;
      redirect_i = 1'b0;
      rst_i = 1'b1;
      drain("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage feeding the decode/control path of the lab CPU.
- Holds the PC and issues word reads to an instruction memory with fixed 1-cycle read latency.
- Buffers returned words in a small FIFO and presents them to decode over a valid/ready handshake, with opcode split out for the control decoder.
- Supports start, redirect (branch/jump) and halt-on-end-address.

Parameters:
- ADDR_W, 32, PC / memory address width.
- DEPTH, 2, instruction buffer entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- END_PC, 32'h0000_0400, first address not fetched; reaching it stops issue.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  one-cycle pulse; leave IDLE and begin fetching.
- imem_req_o  out  1  read request this cycle.
- imem_addr_o  out  ADDR_W  byte address of request (word aligned).
- imem_rdata_i  in  32  read data, valid the cycle after imem_req_o.
- instr_valid_o  out  1  buffer head is valid.
- instr_ready_i  in  1  decode accepts head.
- instr_o  out  32  head instruction word.
- opcode_o  out  7  instr_o[6:0], to control decoder.
- pc_o  out  ADDR_W  address of head instruction.
- redirect_i  in  1  branch/jump taken.
- redirect_pc_i  in  ADDR_W  target address.
- busy_o  out  1  high in RUN or while buffer non-empty.

Behaviour:
- Reset (rst_i==0 at edge): state=IDLE, pc=RESET_PC, FIFO empty, inflight=0. Outputs imem_req_o=0, instr_valid_o=0, busy_o=0, instr_o=0, opcode_o=0, pc_o=RESET_PC. Reset mid-operation discards FIFO and in-flight read.
- States: IDLE -> RUN on start_i. RUN -> DONE when pc==END_PC and no issue. DONE -> RUN on redirect_i with redirect_pc_i<END_PC. DONE holds otherwise. start_i is ignored outside IDLE.
- Issue rule in RUN: imem_req_o = (count + inflight < DEPTH) && pc != END_PC && !redirect_i. imem_addr_o = pc. On issue, pc <= pc+4 and inflight <= 1. inflight clears the next cycle.
- Return: the cycle after issue, imem_rdata_i and its address are pushed to the FIFO, unless killed.
- Credit rule guarantees no push when full; an overflow is a design error, so a bench assertion must never fire.
- Output: head drives instr_o/pc_o/opcode_o. Pop when instr_valid_o && instr_ready_i.
- Push and pop in the same cycle keeps count unchanged. Empty FIFO with a returning word: the word appears at the head the cycle after return (registered FIFO, no bypass).
- Fetch latency: start_i at cycle 0 -> imem_req_o at cycle 1 -> instr_valid_o at cycle 3.
- Redirect (any state except IDLE): FIFO flushed, in-flight response killed, pc <= {redirect_pc_i[ADDR_W-1:2],2'b00}, no issue that cycle. Issue resumes next cycle.
- Redirect has priority over push/pop in the same cycle. A pop coincident with redirect is still counted as consumed by decode.
- PC wrap: pc+4 is modulo 2^ADDR_W; END_PC normally prevents wrap.
- Unaligned redirect target: low two bits forced to 0.
- busy_o = (state==RUN) || count!=0 || inflight.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DONE, 2 bits), opcode constants used by the control decoder (OP_RTYPE=7'b0110011, OP_IMM=7'b0010011), and INSTR_W=32.
- One sub-module: instr_fifo, a parameterized DEPTH-entry sync FIFO with push, pop, flush, count, and {pc,instr} payload.
- Top contains the PC, FSM and credit logic.

Test Plan:
- Reset then start_i at cycle 0, memory returns addr-based words, ready_i=1 -> imem_addr_o 0x0,0x4,0x8 on consecutive cycles; first instr_valid_o at cycle 3 with pc_o=0x0; one instruction per cycle thereafter.
- Backpressure: instr_ready_i=0 for 5 cycles after first valid -> at most DEPTH entries held, imem_req_o drops to 0. On release, order is pc 0x0,0x4,0x8 with no loss or duplication.
- Redirect to 0x103 while a request is in flight and the FIFO holds 2 -> the next valid is pc_o=0x100; the killed word never appears.
- END_PC=0x10 -> exactly 4 instructions delivered (0x0..0xC), state DONE, busy_o falls after the last pop. A redirect to 0x8 resumes fetching with 0x8 and 0xC.
- rst_i=0 asserted while in RUN with a full FIFO -> next cycle instr_valid_o=0, imem_req_o=0, pc_o=RESET_PC. start_i is required to resume.
- Opcode pass-through: word 0x00500093 (addi) -> opcode_o=7'b0010011; word 0x002081B3 (add) -> opcode_o=7'b0110011.
